// File: rtl/bus_arbiter_rr.sv
// N-master burst arbiter (round-robin or fixed priority) onto one slave port.
// Also keeps a saturating completed-burst counter and a sticky done flag.
module bus_arbiter_rr #(
    parameter int unsigned N_MASTERS  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LEN_W      = 4,
    parameter bit          PRIO_MODE  = 1'b0,
    parameter int unsigned TXN_TARGET = 0,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*LEN_W-1:0]    m_len,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*DATA_W-1:0]   m_data,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic [N_MASTERS-1:0]          m_gnt,
    output logic                          s_valid,
    output logic [DATA_W-1:0]             s_data,
    output logic                          s_last,
    output logic [ID_W-1:0]               s_id,
    input  logic                          s_ready,
    output logic [CNT_W-1:0]              txn_count,
    output logic                          done
);

    // Per-master vectors are padded to a power of two so an ID_W-bit index
    // always lands inside the array, including the N_MASTERS=1 case.
    localparam int unsigned NP = 1 << ID_W;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [LEN_W-1:0]  beats_left;

    logic [NP-1:0]     req_ext;
    logic [NP-1:0]     valid_ext;
    logic [NP-1:0]     ready_ext;
    logic [DATA_W-1:0] data_arr [NP];
    logic [LEN_W-1:0]  len_arr  [NP];

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   scan_start;
    logic [ID_W:0]     cand;
    logic              xfer;

    always_comb begin
        req_ext   = NP'(m_req);
        valid_ext = NP'(m_valid);
    end

    for (genvar gi = 0; gi < NP; gi++) begin : g_slice
        if (gi < N_MASTERS) begin : g_real
            assign data_arr[gi] = m_data[gi*DATA_W +: DATA_W];
            assign len_arr[gi]  = m_len[gi*LEN_W +: LEN_W];
        end else begin : g_pad
            assign data_arr[gi] = '0;
            assign len_arr[gi]  = '0;
        end
    end

    // Scan N_MASTERS candidates starting at rr_ptr (or 0 in fixed priority),
    // wrapping modulo N_MASTERS; first requester found wins.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        scan_start = PRIO_MODE ? '0 : rr_ptr;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            cand = {1'b0, scan_start} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_MASTERS))
                cand = cand - (ID_W+1)'(N_MASTERS);
            if (!win_found && req_ext[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        s_valid   = 1'b0;
        s_data    = '0;
        ready_ext = '0;
        if (state == BURST) begin
            s_valid           = valid_ext[s_id];
            s_data            = data_arr[s_id];
            ready_ext[s_id]   = s_ready;
        end
        m_ready = ready_ext[N_MASTERS-1:0];
        s_last  = (state == BURST) && (beats_left == '0);
        xfer    = s_valid && s_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            beats_left <= '0;
            m_gnt      <= '0;
            s_id       <= '0;
            txn_count  <= '0;
            done       <= 1'b0;
        end else begin
            if (TXN_TARGET != 0 && txn_count >= CNT_W'(TXN_TARGET))
                done <= 1'b1;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state      <= BURST;
                        s_id       <= win_idx;
                        m_gnt      <= N_MASTERS'(1) << win_idx;
                        beats_left <= len_arr[win_idx];
                    end
                end
                BURST: begin
                    if (xfer) begin
                        if (beats_left == '0) begin
                            state  <= IDLE;
                            m_gnt  <= '0;
                            rr_ptr <= (s_id == ID_W'(N_MASTERS-1)) ? '0 : s_id + ID_W'(1);
                            if (txn_count != '1)
                                txn_count <= txn_count + CNT_W'(1);
                        end else begin
                            beats_left <= beats_left - LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: round-robin instance (done target 3) and a fixed-priority
// instance with a 3-bit counter, both fed from the same master stimulus.
module tb_bus_arbiter_rr;

    logic         clk;
    logic         rst;
    logic [3:0]   m_req;
    logic [15:0]  m_len;
    logic [3:0]   m_valid;
    logic [127:0] m_data;
    logic         s_ready;

    logic [3:0]   r_m_ready, r_m_gnt;
    logic         r_s_valid, r_s_last, r_done;
    logic [31:0]  r_s_data;
    logic [1:0]   r_s_id;
    logic [15:0]  r_txn_count;

    logic [3:0]   f_m_ready, f_m_gnt;
    logic         f_s_valid, f_s_last, f_done;
    logic [31:0]  f_s_data;
    logic [1:0]   f_s_id;
    logic [2:0]   f_txn_count;

    int n_vec = 0;
    int n_err = 0;

    bus_arbiter_rr #(.N_MASTERS(4), .DATA_W(32), .LEN_W(4), .PRIO_MODE(1'b0),
                     .TXN_TARGET(3), .CNT_W(16)) dut_rr (
        .clk(clk), .rst(rst), .m_req(m_req), .m_len(m_len), .m_valid(m_valid),
        .m_data(m_data), .m_ready(r_m_ready), .m_gnt(r_m_gnt), .s_valid(r_s_valid),
        .s_data(r_s_data), .s_last(r_s_last), .s_id(r_s_id), .s_ready(s_ready),
        .txn_count(r_txn_count), .done(r_done)
    );

    bus_arbiter_rr #(.N_MASTERS(4), .DATA_W(32), .LEN_W(4), .PRIO_MODE(1'b1),
                     .TXN_TARGET(0), .CNT_W(3)) dut_fp (
        .clk(clk), .rst(rst), .m_req(m_req), .m_len(m_len), .m_valid(m_valid),
        .m_data(m_data), .m_ready(f_m_ready), .m_gnt(f_m_gnt), .s_valid(f_s_valid),
        .s_data(f_s_data), .s_last(f_s_last), .s_id(f_s_id), .s_ready(s_ready),
        .txn_count(f_txn_count), .done(f_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    logic rdy_tab  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic last_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int xfers;

    initial begin
        rst     = 1'b1;
        m_req   = 4'b1111;
        m_valid = 4'b1111;
        m_len   = '0;
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) m_data[i*32 +: 32] = 32'hDA7A_0000 + i;

        // Reset held 3 cycles with every master requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", r_m_gnt, 0);
            check("rst_svalid", r_s_valid, 0);
        end
        check("rst_count", r_txn_count, 0);
        check("rst_done", r_done, 0);
        check("rst_sid", r_s_id, 0);
        check("rst_slast", r_s_last, 0);
        check("rst_mready", r_m_ready, 0);
        check("rst_sdata", r_s_data, 0);
        rst = 1'b0;

        // Round-robin fairness with single-beat bursts; done after count 3
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_gnt", r_m_gnt, 64'(1) << order[k]);
            check("rr_sid", r_s_id, order[k]);
            check("rr_last", r_s_last, 1);
            check("rr_mready", r_m_ready, 64'(1) << order[k]);
            check("rr_done_g", r_done, (k >= 3) ? 1 : 0);
            tick();
            check("rr_idle_gnt", r_m_gnt, 0);
            check("rr_idle_svalid", r_s_valid, 0);
            check("rr_count", r_txn_count, k + 1);
            check("rr_done_i", r_done, (k >= 3) ? 1 : 0);
        end

        // Fixed priority vs round-robin with requests 1010; fp counter saturates
        m_req = 4'b1010;
        do_reset(2);
        check("rst_done_clr", r_done, 0);
        check("rst_count_clr", r_txn_count, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("fp_gnt", f_m_gnt, 4'b0010);
            check("fp_sid", f_s_id, 1);
            check("rr_alt_sid", r_s_id, (k % 2 == 1) ? 3 : 1);
            tick();
            check("fp_count", f_txn_count, (k + 1 > 7) ? 7 : k + 1);
            check("fp_done", f_done, 0);
        end

        // 4-beat burst from master 2 with a 2-cycle slave stall
        m_req = 4'b0100;
        m_len = '0;
        m_len[11:8] = 4'd3;
        do_reset(1);
        tick();
        m_req = 4'b0000;
        m_len[11:8] = 4'd0;
        check("bst_gnt", r_m_gnt, 4'b0100);
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            s_ready = rdy_tab[c];
            #1;
            check("bst_sid", r_s_id, 2);
            check("bst_valid", r_s_valid, 1);
            check("bst_last", r_s_last, last_tab[c]);
            check("bst_data", r_s_data, 32'hDA7A_0002);
            check("bst_mready", r_m_ready, rdy_tab[c] ? 4'b0100 : 4'b0000);
            if (r_s_valid && s_ready) xfers++;
            tick();
        end
        check("bst_xfers", xfers, 4);
        check("bst_end_gnt", r_m_gnt, 0);
        check("bst_end_valid", r_s_valid, 0);
        check("bst_end_last", r_s_last, 0);
        check("bst_count", r_txn_count, 1);
        tick();
        check("bst_no_regrant", r_m_gnt, 0);

        // Reset during beat 2 of a 4-beat burst from master 3 (rr_ptr is 3)
        m_req = 4'b1000;
        m_len[15:12] = 4'd3;
        tick();
        check("rmb_gnt", r_m_gnt, 4'b1000);
        check("rmb_sid", r_s_id, 3);
        tick();
        check("rmb_beat2_valid", r_s_valid, 1);
        check("rmb_beat2_last", r_s_last, 0);
        rst = 1'b1;
        m_req = 4'b1110;
        tick();
        check("rmb_svalid", r_s_valid, 0);
        check("rmb_gnt_clr", r_m_gnt, 0);
        check("rmb_last", r_s_last, 0);
        check("rmb_count", r_txn_count, 0);
        check("rmb_mready", r_m_ready, 0);
        rst = 1'b0;
        tick();
        check("rmb_regrant", r_m_gnt, 4'b0010);
        check("rmb_resid", r_s_id, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
